id_stage: RTL and testbench

Instruction-decode stage of the 5-stage 16-bit pipeline. Sits between the IF/ID register and EX and drives the read address ports of the 16x16 register file. It decodes the instruction, reads both source operands with write-back bypass, and detects load-use hazards, stalling IF and inserting a bubble when one occurs. It owns the ID/EX pipeline register.

---
 rtl/id_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes the IF/ID instruction, reads operands with
// write-back bypass, stalls on load-use hazards and owns the ID/EX register.
module id_stage #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_valid,
    input  logic [DW-1:0] if_instr,
    input  logic [DW-1:0] if_pc,
    input  logic          flush,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    output logic          id_stall,
    output logic          ex_valid,
    output logic [3:0]    ex_opcode,
    output logic [AW-1:0] ex_rd,
    output logic [DW-1:0] ex_op1,
    output logic [DW-1:0] ex_op2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_branch
);

    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;

    function automatic logic signed [DW-1:0] sext4(input logic [3:0] v);
        return $signed({{(DW-4){v[3]}}, v});
    endfunction

    function automatic logic signed [DW-1:0] sext12(input logic [11:0] v);
        return $signed({{(DW-12){v[11]}}, v});
    endfunction

    logic [3:0]           w_opcode;
    logic [AW-1:0]        w_rd;
    logic [AW-1:0]        w_rs1;
    logic [AW-1:0]        w_rs2;
    logic                 w_use_rs1;
    logic                 w_use_src2;
    logic                 w_rd_is_src;
    logic                 w_regwrite;
    logic                 w_memread;
    logic                 w_memwrite;
    logic                 w_branch;
    logic signed [DW-1:0] w_imm;
    logic [DW-1:0]        w_op1;
    logic [DW-1:0]        w_op2;
    logic                 w_hazard;
    logic                 w_load;

    logic                 r_vld_p1;
    logic [3:0]           r_opcode_p1;
    logic [AW-1:0]        r_rd_p1;
    logic [DW-1:0]        r_op1_p1;
    logic [DW-1:0]        r_op2_p1;
    logic signed [DW-1:0] r_imm_p1;
    logic [DW-1:0]        r_pc_p1;
    logic                 r_regwrite_p1;
    logic                 r_memread_p1;
    logic                 r_memwrite_p1;
    logic                 r_branch_p1;

    assign w_opcode = if_instr[15:12];
    assign w_rd     = if_instr[11:8];
    assign w_rs1    = if_instr[7:4];
    assign w_rs2    = if_instr[3:0];

    always_comb begin
        w_use_rs1   = 1'b0;
        w_use_src2  = 1'b0;
        w_rd_is_src = 1'b0;
        w_regwrite  = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_branch    = 1'b0;
        w_imm       = '0;
        if (w_opcode <= 4'h7) begin
            w_use_rs1  = 1'b1;
            w_use_src2 = 1'b1;
            w_regwrite = 1'b1;
        end else begin
            case (w_opcode)
                OP_ADDI: begin
                    w_use_rs1  = 1'b1;
                    w_regwrite = 1'b1;
                    w_imm      = sext4(w_rs2);
                end
                OP_LW: begin
                    w_use_rs1  = 1'b1;
                    w_regwrite = 1'b1;
                    w_memread  = 1'b1;
                    w_imm      = sext4(w_rs2);
                end
                OP_SW: begin
                    w_use_rs1   = 1'b1;
                    w_use_src2  = 1'b1;
                    w_rd_is_src = 1'b1;
                    w_memwrite  = 1'b1;
                    w_imm       = sext4(w_rs2);
                end
                OP_BEQ: begin
                    w_use_rs1   = 1'b1;
                    w_use_src2  = 1'b1;
                    w_rd_is_src = 1'b1;
                    w_branch    = 1'b1;
                end
                OP_JMP: begin
                    w_branch = 1'b1;
                    w_imm    = sext12(if_instr[11:0]);
                end
                default: ;
            endcase
        end
    end

    assign rf_raddr1 = w_rs1;
    assign rf_raddr2 = w_rd_is_src ? w_rd : w_rs2;

    // WB writes land on the clock edge; bypass covers the same-cycle read.
    assign w_op1 = (wb_regwrite && (wb_waddr == rf_raddr1)) ? wb_wdata : rf_rdata1;
    assign w_op2 = (wb_regwrite && (wb_waddr == rf_raddr2)) ? wb_wdata : rf_rdata2;

    assign w_hazard = if_valid & r_vld_p1 & r_memread_p1 &
                      ((w_use_rs1  & (r_rd_p1 == rf_raddr1)) |
                       (w_use_src2 & (r_rd_p1 == rf_raddr2)));

    assign id_stall = w_hazard & ~flush & ~reset;
    assign w_load   = if_valid & ~flush & ~w_hazard;

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1      <= 1'b0;
            r_regwrite_p1 <= 1'b0;
            r_memread_p1  <= 1'b0;
            r_memwrite_p1 <= 1'b0;
            r_branch_p1   <= 1'b0;
            r_opcode_p1   <= '0;
            r_rd_p1       <= '0;
            r_op1_p1      <= '0;
            r_op2_p1      <= '0;
            r_imm_p1      <= '0;
            r_pc_p1       <= '0;
        end else begin
            r_vld_p1      <= w_load;
            r_regwrite_p1 <= w_load & w_regwrite;
            r_memread_p1  <= w_load & w_memread;
            r_memwrite_p1 <= w_load & w_memwrite;
            r_branch_p1   <= w_load & w_branch;
            r_opcode_p1   <= w_opcode;
            r_rd_p1       <= w_rd;
            r_op1_p1      <= w_op1;
            r_op2_p1      <= w_op2;
            r_imm_p1      <= w_imm;
            r_pc_p1       <= if_pc;
        end
    end

    assign ex_valid    = r_vld_p1;
    assign ex_opcode   = r_opcode_p1;
    assign ex_rd       = r_rd_p1;
    assign ex_op1      = r_op1_p1;
    assign ex_op2      = r_op2_p1;
    assign ex_imm      = r_imm_p1;
    assign ex_pc       = r_pc_p1;
    assign ex_regwrite = r_regwrite_p1;
    assign ex_memread  = r_memread_p1;
    assign ex_memwrite = r_memwrite_p1;
    assign ex_branch   = r_branch_p1;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus pushes expected stall and ID/EX
// contents per cycle, a monitor pops and compares on the falling edge.
module tb_id_stage;

    typedef struct packed {
        logic        stall;
        logic        vld;
        logic        chk;
        logic [3:0]  ctl;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = '0;
    logic [15:0] if_pc = '0;
    logic        flush = 1'b0;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic        wb_regwrite = 1'b0;
    logic [3:0]  wb_waddr = '0;
    logic [15:0] wb_wdata = '0;
    logic        id_stall;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_rd;
    logic [15:0] ex_op1, ex_op2, ex_imm, ex_pc;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch;

    logic [15:0] rf [16];
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    id_stage #(.DW(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_regwrite(wb_regwrite),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch)
    );

    function automatic exp_t ins(input logic st, input logic [3:0] op, rd,
                                 input logic [15:0] a, b, im, pc,
                                 input logic rw, mr, mw, br);
        exp_t e;
        e.stall = st; e.vld = 1'b1; e.chk = 1'b1; e.ctl = {rw, mr, mw, br};
        e.op = op; e.rd = rd; e.op1 = a; e.op2 = b; e.imm = im; e.pc = pc;
        return e;
    endfunction

    function automatic exp_t bub(input logic st);
        exp_t e;
        e = '0;
        e.stall = st;
        return e;
    endfunction

    function automatic exp_t zer();
        exp_t e;
        e = '0;
        e.chk = 1'b1;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
        end
    endtask

    task automatic check_ex(input exp_t e);
        chk("ex_valid", {15'd0, ex_valid}, {15'd0, e.vld});
        chk("ex_ctl", {12'd0, ex_regwrite, ex_memread, ex_memwrite, ex_branch}, {12'd0, e.ctl});
        if (e.chk) begin
            chk("ex_op_rd", {8'd0, ex_opcode, ex_rd}, {8'd0, e.op, e.rd});
            chk("ex_op1", ex_op1, e.op1);
            chk("ex_op2", ex_op2, e.op2);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_pc", ex_pc, e.pc);
        end
    endtask

    task automatic step(input logic rs, v, input logic [15:0] ins_w, pc,
                        input logic fl, wbw, input logic [3:0] wa,
                        input logic [15:0] wd, input exp_t e);
        @(posedge clk);
        #1;
        reset = rs; if_valid = v; if_instr = ins_w; if_pc = pc; flush = fl;
        wb_regwrite = wbw; wb_waddr = wa; wb_wdata = wd;
        sb.push_back(e);
    endtask

    // Monitor: stall belongs to the current cycle, ex_* to the entry of the previous one.
    initial begin
        exp_t prev;
        exp_t cur;
        bit   have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (have_prev) check_ex(prev);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                chk("id_stall", {15'd0, id_stall}, {15'd0, cur.stall});
                prev = cur;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h0111);
        rf[0] = 16'h1000; rf[1] = 16'h0005; rf[2] = 16'h0003; rf[3] = 16'h0333;
        rf[4] = 16'h0044; rf[6] = 16'h0066; rf[15] = 16'hF0F0;

        step(1, 1, 16'h0312, 16'h0010, 0, 0, 0, 0, zer());
        step(1, 1, 16'h0312, 16'h0010, 0, 0, 0, 0, zer());
        step(0, 1, 16'h0312, 16'h0010, 0, 0, 0, 0, ins(0, 4'h0, 4'd3, 16'h0005, 16'h0003, 16'h0000, 16'h0010, 1, 0, 0, 0));
        step(0, 1, 16'h0312, 16'h0012, 0, 1, 2, 16'hBEEF, ins(0, 4'h0, 4'd3, 16'h0005, 16'hBEEF, 16'h0000, 16'h0012, 1, 0, 0, 0));
        step(0, 1, 16'h9410, 16'h0014, 0, 0, 0, 0, ins(0, 4'h9, 4'd4, 16'h0005, 16'h1000, 16'h0000, 16'h0014, 1, 1, 0, 0));
        step(0, 1, 16'h0541, 16'h0016, 0, 0, 0, 0, bub(1));
        step(0, 1, 16'h0541, 16'h0016, 0, 0, 0, 0, ins(0, 4'h0, 4'd5, 16'h0044, 16'h0005, 16'h0000, 16'h0016, 1, 0, 0, 0));
        step(0, 1, 16'h9410, 16'h0018, 0, 0, 0, 0, ins(0, 4'h9, 4'd4, 16'h0005, 16'h1000, 16'h0000, 16'h0018, 1, 1, 0, 0));
        step(0, 1, 16'h8561, 16'h001A, 0, 0, 0, 0, ins(0, 4'h8, 4'd5, 16'h0066, 16'h0005, 16'h0001, 16'h001A, 1, 0, 0, 0));
        step(0, 1, 16'h9410, 16'h001C, 0, 0, 0, 0, ins(0, 4'h9, 4'd4, 16'h0005, 16'h1000, 16'h0000, 16'h001C, 1, 1, 0, 0));
        step(0, 1, 16'h8564, 16'h001E, 0, 0, 0, 0, ins(0, 4'h8, 4'd5, 16'h0066, 16'h0044, 16'h0004, 16'h001E, 1, 0, 0, 0));
        step(0, 1, 16'h9410, 16'h0020, 0, 0, 0, 0, ins(0, 4'h9, 4'd4, 16'h0005, 16'h1000, 16'h0000, 16'h0020, 1, 1, 0, 0));
        step(0, 1, 16'h0541, 16'h0022, 1, 0, 0, 0, bub(0));
        step(0, 1, 16'h856F, 16'h0024, 0, 0, 0, 0, ins(0, 4'h8, 4'd5, 16'h0066, 16'hF0F0, 16'hFFFF, 16'h0024, 1, 0, 0, 0));
        step(0, 1, 16'hC800, 16'h0026, 0, 0, 0, 0, ins(0, 4'hC, 4'd8, 16'h1000, 16'h1000, 16'hF800, 16'h0026, 0, 0, 0, 1));
        step(0, 1, 16'hA325, 16'h0028, 0, 0, 0, 0, ins(0, 4'hA, 4'd3, 16'h0003, 16'h0333, 16'h0005, 16'h0028, 0, 0, 1, 0));
        step(0, 1, 16'h9310, 16'h002A, 0, 0, 0, 0, ins(0, 4'h9, 4'd3, 16'h0005, 16'h1000, 16'h0000, 16'h002A, 1, 1, 0, 0));
        step(0, 1, 16'hA325, 16'h002C, 0, 0, 0, 0, bub(1));
        step(0, 1, 16'hA325, 16'h002C, 0, 0, 0, 0, ins(0, 4'hA, 4'd3, 16'h0003, 16'h0333, 16'h0005, 16'h002C, 0, 0, 1, 0));
        step(0, 1, 16'hB120, 16'h002E, 0, 0, 0, 0, ins(0, 4'hB, 4'd1, 16'h0003, 16'h0005, 16'h0000, 16'h002E, 0, 0, 0, 1));
        step(0, 1, 16'h0777, 16'h0030, 0, 1, 7, 16'hCAFE, ins(0, 4'h0, 4'd7, 16'hCAFE, 16'hCAFE, 16'h0000, 16'h0030, 1, 0, 0, 0));
        step(0, 1, 16'h9210, 16'h0032, 0, 0, 0, 0, ins(0, 4'h9, 4'd2, 16'h0005, 16'h1000, 16'h0000, 16'h0032, 1, 1, 0, 0));
        step(0, 1, 16'h0312, 16'h0034, 0, 1, 2, 16'hBEEF, bub(1));
        step(0, 1, 16'h0312, 16'h0034, 0, 0, 0, 0, ins(0, 4'h0, 4'd3, 16'h0005, 16'h0003, 16'h0000, 16'h0034, 1, 0, 0, 0));
        step(0, 1, 16'hD123, 16'h0036, 0, 0, 0, 0, ins(0, 4'hD, 4'd1, 16'h0003, 16'h0333, 16'h0000, 16'h0036, 0, 0, 0, 0));
        step(0, 0, 16'h0312, 16'h0038, 0, 0, 0, 0, bub(0));
        step(0, 1, 16'h9410, 16'h0038, 0, 0, 0, 0, ins(0, 4'h9, 4'd4, 16'h0005, 16'h1000, 16'h0000, 16'h0038, 1, 1, 0, 0));
        step(1, 1, 16'h0541, 16'h003A, 0, 0, 0, 0, zer());
        step(0, 1, 16'h0541, 16'h003A, 0, 0, 0, 0, ins(0, 4'h0, 4'd5, 16'h0044, 16'h0005, 16'h0000, 16'h003A, 1, 0, 0, 0));
        step(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, bub(0));

        repeat (3) @(negedge clk);
        #2;
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
